video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 720p video signal generator in the HDMI output path.
- Produces raster counters for the renderer, plus sync, active-draw, new-frame and frame-count signals for the TMDS encoders.
- Every timing field and both sync polarities are parameters.
- Includes a DELAY-stage flag pipeline so sync and active-draw line up with a renderer of known pixel latency.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (cycles)
- H_SYNC, 40, horizontal sync width (cycles)
- H_BP, 220, horizontal back porch (cycles)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- FPS, 60, frame-counter modulus
- HS_POL, 1, 1 = sync asserted high, 0 = asserted low
- VS_POL, 1, same convention for vertical sync
- DELAY, 0, pipeline stages on hs/vs/ad/nf/fc relative to the counts (0..15)
- Derived localparams:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - HW = $clog2(H_TOTAL)
  - VW = $clog2(V_TOTAL)
  - FW = $clog2(FPS)

Ports:
- clk_pixel_in  input  1  pixel clock
- rst_in  input  1  synchronous, active-high reset
- hcount_out  output  HW  current pixel column, 0..H_TOTAL-1
- vcount_out  output  VW  current line, 0..V_TOTAL-1
- hs_out  output  1  horizontal sync, polarity per HS_POL, delayed DELAY cycles
- vs_out  output  1  vertical sync, polarity per VS_POL, delayed DELAY cycles
- ad_out  output  1  active draw, delayed DELAY cycles
- nf_out  output  1  one-cycle new-frame pulse, delayed DELAY cycles
- fc_out  output  FW  frame count, 0..FPS-1, delayed DELAY cycles

Behaviour:
- One clock domain; reset is synchronous and active-high; all outputs registered.
- Reset (edge with rst_in=1):
  - hcount=0, vcount=0, fc=0.
  - ad=0, nf=0.
  - hs_out=~HS_POL, vs_out=~VS_POL (deasserted level).
  - Every delay stage is loaded with the same deasserted values.
- First edge with rst_in=0: counts advance to (1,0). Pixel (0,0) of the first frame after reset is never flagged active; this is intended.
- Counter stepping:
  - hcount increments every cycle.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Flags are computed from the next-state counts and registered with them, so at DELAY=0 they describe the counts shown in the same cycle:
  - ad = hcount<H_ACTIVE && vcount<V_ACTIVE.
  - hs asserted while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, all lines.
  - vs asserted while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, all pixels of those lines.
  - nf=1 only when hcount==H_ACTIVE && vcount==V_ACTIVE (first blanking pixel after the last active line).
- Frame count:
  - fc increments in the same cycle nf is set.
  - FPS-1 wraps to 0.
  - fc_out holds its value between pulses.
- Delay:
  - DELAY=0 means a pure pass-through; no extra register.
  - DELAY=N means the flags and fc for count (h,v) appear N cycles after (h,v) is on hcount_out/vcount_out.
  - Counts are never delayed.
- Reset mid-frame: takes effect on that edge, clears the whole pipeline, and drops any in-flight nf.
- Elaboration checks: every timing parameter >=1, FPS>=1, DELAY<=15. A violation is a fatal elaboration error.

Decomposition:
- Package video_pkg:
  - struct video_timing_t (h/v active, fp, sync, bp, polarities).
  - localparams TIMING_720P and TIMING_480P (640x480: 16/96/48, 10/2/33, negative polarity).
  - function timing_total() for H_TOTAL and V_TOTAL.
- One sub-module, sig_delay:
  - Parametrised WIDTH and DEPTH shift register with synchronous reset value RST_VAL.
  - DEPTH=0 passes through combinationally.
  - Carries {hs, vs, ad, nf, fc}.

Test Plan:
- Default 720p, rst_in released → over one frame:
  - exactly 1650*750=1,237,500 cycles between nf pulses;
  - nf coincides with hcount=1280, vcount=720;
  - hs high for 40 cycles starting hcount=1390 on every line;
  - vs high for lines 725..729.
- Small params (H 4/1/1/1, V 3/1/1/1, FPS=3), run 7 frames → fc_out sequence 1,2,0,1,2,0,1, each change coincident with nf; ad high count per frame = 12.
- TIMING_480P, HS_POL=0, VS_POL=0 → hs_out low exactly for hcount 656..751, vs_out low for lines 490..491, high during reset.
- DELAY=3, 720p → ad_out rises exactly 3 cycles after hcount_out=0 on vcount_out=0; hs_out rises 3 cycles after hcount_out=1390.
- Reset asserted at hcount=700, vcount=300 for 2 cycles → counts 0, ad/nf 0, syncs deasserted, delay stages flushed; first cycle after release shows (1,0).
- FPS=1 edge case → fc_out constant 0, nf still pulses once per frame.

Source files
------------

// File: rtl/video_pkg.sv
// Shared timing descriptions for the video output path.
package video_pkg;

    // One complete raster description: horizontal fields in pixels, vertical fields in lines.
    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        bit          hs_pol;
        bit          vs_pol;
    } video_timing_t;

    localparam video_timing_t TIMING_720P = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
        hs_pol:   1'b1, vs_pol: 1'b1
    };

    localparam video_timing_t TIMING_480P = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        hs_pol:   1'b0, vs_pol: 1'b0
    };

    // Total period of one axis (line length or frame height).
    function automatic int unsigned timing_total(input int unsigned active,
                                                 input int unsigned fp,
                                                 input int unsigned sync,
                                                 input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with synchronous reset; DEPTH=0 is a plain wire.
module sig_delay #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        assign q_o = d_i;

        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift one stage per cycle; reset loads every stage with the idle value.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters plus sync, active-draw,
// new-frame and frame-count flags, with an optional flag delay to match renderer latency.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = TIMING_720P.h_active,
    parameter int unsigned H_FP     = TIMING_720P.h_fp,
    parameter int unsigned H_SYNC   = TIMING_720P.h_sync,
    parameter int unsigned H_BP     = TIMING_720P.h_bp,
    parameter int unsigned V_ACTIVE = TIMING_720P.v_active,
    parameter int unsigned V_FP     = TIMING_720P.v_fp,
    parameter int unsigned V_SYNC   = TIMING_720P.v_sync,
    parameter int unsigned V_BP     = TIMING_720P.v_bp,
    parameter int unsigned FPS      = 60,
    parameter bit          HS_POL   = TIMING_720P.hs_pol,
    parameter bit          VS_POL   = TIMING_720P.vs_pol,
    parameter int unsigned DELAY    = 0,
    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    // Widths floor at 1 so degenerate totals (e.g. FPS=1) still give a legal vector.
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1,
    localparam int unsigned FW      = (FPS > 1) ? $clog2(FPS) : 1
) (
    input  logic          clk_pixel_in,
    input  logic          rst_in,
    output logic [HW-1:0] hcount_out,
    output logic [VW-1:0] vcount_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          ad_out,
    output logic          nf_out,
    output logic [FW-1:0] fc_out
);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $fatal(1, "video_timing_gen: every timing field must be >= 1");
    end
    if (FPS == 0) begin : g_bad_fps
        $fatal(1, "video_timing_gen: FPS must be >= 1");
    end
    if (DELAY > 15) begin : g_bad_delay
        $fatal(1, "video_timing_gen: DELAY must be <= 15");
    end

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_ON  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_SYNC_ON  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [FW-1:0] FC_LAST    = FW'(FPS - 1);

    localparam int unsigned   FLAG_W     = 4 + FW;
    localparam logic [FLAG_W-1:0] FLAG_IDLE = {~HS_POL, ~VS_POL, 1'b0, 1'b0, {FW{1'b0}}};

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          ad_q, ad_d;
    logic          nf_q, nf_d;
    logic [FW-1:0] fc_q, fc_d;

    // Next raster position and the flags that describe it, so flags and counts register together.
    always_comb begin
        hcount_d = hcount_q + HW'(1);
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
        end

        ad_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);
        hs_d = ((hcount_d >= H_SYNC_ON) && (hcount_d < H_SYNC_OFF)) ? HS_POL : ~HS_POL;
        vs_d = ((vcount_d >= V_SYNC_ON) && (vcount_d < V_SYNC_OFF)) ? VS_POL : ~VS_POL;
        nf_d = (hcount_d == H_ACT) && (vcount_d == V_ACT);

        fc_d = fc_q;
        if (nf_d) begin
            fc_d = (fc_q == FC_LAST) ? '0 : fc_q + FW'(1);
        end
    end

    // Counter and flag registers; reset parks everything at (0,0) with syncs deasserted.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            ad_q     <= 1'b0;
            nf_q     <= 1'b0;
            fc_q     <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            ad_q     <= ad_d;
            nf_q     <= nf_d;
            fc_q     <= fc_d;
        end
    end

    logic [FLAG_W-1:0] flags_now;
    logic [FLAG_W-1:0] flags_dly;

    assign flags_now = {hs_q, vs_q, ad_q, nf_q, fc_q};

    sig_delay #(
        .WIDTH   (FLAG_W),
        .DEPTH   (DELAY),
        .RST_VAL (FLAG_IDLE)
    ) u_flag_delay (
        .clk_i (clk_pixel_in),
        .rst_i (rst_in),
        .d_i   (flags_now),
        .q_o   (flags_dly)
    );

    // Counts are never delayed; only the flag bundle goes through the pipeline.
    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign hs_out     = flags_dly[FLAG_W-1];
    assign vs_out     = flags_dly[FLAG_W-2];
    assign ad_out     = flags_dly[FLAG_W-3];
    assign nf_out     = flags_dly[FLAG_W-4];
    assign fc_out     = flags_dly[FW-1:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Four differently-configured generators share one clock and reset; each is compared every
// cycle against an arithmetic model driven only by the number of edges since reset.
module tb_video_timing_gen;
    import video_pkg::*;

    logic clk;
    logic rst_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // u0: tiny raster, FPS=3, no delay
    logic [2:0]  hc0; logic [2:0] vc0; logic hs0, vs0, ad0, nf0; logic [1:0] fc0;
    // u1: 480p horizontal timing, short frame, negative syncs, DELAY=3
    logic [9:0]  hc1; logic [3:0] vc1; logic hs1, vs1, ad1, nf1; logic [1:0] fc1;
    // u2: FPS=1, DELAY=15, mixed polarity
    logic [3:0]  hc2; logic [2:0] vc2; logic hs2, vs2, ad2, nf2; logic [0:0] fc2;
    // u3: default 720p, DELAY=3
    logic [10:0] hc3; logic [9:0] vc3; logic hs3, vs3, ad3, nf3; logic [5:0] fc3;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FPS(3), .HS_POL(1'b1), .VS_POL(1'b1), .DELAY(0)
    ) u0 (
        .clk_pixel_in(clk), .rst_in(rst_in), .hcount_out(hc0), .vcount_out(vc0),
        .hs_out(hs0), .vs_out(vs0), .ad_out(ad0), .nf_out(nf0), .fc_out(fc0)
    );

    video_timing_gen #(
        .H_ACTIVE(TIMING_480P.h_active), .H_FP(TIMING_480P.h_fp),
        .H_SYNC(TIMING_480P.h_sync), .H_BP(TIMING_480P.h_bp),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .FPS(3), .HS_POL(TIMING_480P.hs_pol), .VS_POL(TIMING_480P.vs_pol), .DELAY(3)
    ) u1 (
        .clk_pixel_in(clk), .rst_in(rst_in), .hcount_out(hc1), .vcount_out(vc1),
        .hs_out(hs1), .vs_out(vs1), .ad_out(ad1), .nf_out(nf1), .fc_out(fc1)
    );

    video_timing_gen #(
        .H_ACTIVE(3), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .FPS(1), .HS_POL(1'b0), .VS_POL(1'b1), .DELAY(15)
    ) u2 (
        .clk_pixel_in(clk), .rst_in(rst_in), .hcount_out(hc2), .vcount_out(vc2),
        .hs_out(hs2), .vs_out(vs2), .ad_out(ad2), .nf_out(nf2), .fc_out(fc2)
    );

    video_timing_gen #(
        .DELAY(3)
    ) u3 (
        .clk_pixel_in(clk), .rst_in(rst_in), .hcount_out(hc3), .vcount_out(vc3),
        .hs_out(hs3), .vs_out(vs3), .ad_out(ad3), .nf_out(nf3), .fc_out(fc3)
    );

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, fps, dly;
        bit hpol, vpol;
    } cfg_t;

    cfg_t cfg [4];
    int   k;          // non-reset edges since the last reset edge
    int   n_tests;
    int   n_fail;
    int   nf_seen0;   // new-frame pulses seen on u0 during the long clean run

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Reference: position is k modulo the frame; flags describe the position DELAY edges earlier;
    // fc counts how many new-frame positions have been passed since reset.
    task automatic model(input cfg_t c, input int kk, output int eh, output int ev,
                         output int ehs, output int evs, output int ead, output int enf,
                         output int efc);
        int ht, vt, ft, p, m, q, qh, qv, nfp;
        ht  = c.ha + c.hfp + c.hsw + c.hbp;
        vt  = c.va + c.vfp + c.vsw + c.vbp;
        ft  = ht * vt;
        p   = kk % ft;
        eh  = p % ht;
        ev  = p / ht;
        m   = kk - c.dly;
        nfp = c.va * ht + c.ha;
        if (m < 1) begin
            ehs = int'(!c.hpol);
            evs = int'(!c.vpol);
            ead = 0;
            enf = 0;
            efc = 0;
        end else begin
            q   = m % ft;
            qh  = q % ht;
            qv  = q / ht;
            ead = int'(qh < c.ha && qv < c.va);
            ehs = (qh >= c.ha + c.hfp && qh < c.ha + c.hfp + c.hsw) ? int'(c.hpol)
                                                                    : int'(!c.hpol);
            evs = (qv >= c.va + c.vfp && qv < c.va + c.vfp + c.vsw) ? int'(c.vpol)
                                                                    : int'(!c.vpol);
            enf = int'(qh == c.ha && qv == c.va);
            efc = (m >= nfp) ? (((m - nfp) / ft + 1) % c.fps) : 0;
        end
    endtask

    task automatic check_unit(input string u, input cfg_t c, input logic [31:0] oh,
                              input logic [31:0] ov, input logic ohs, input logic ovs,
                              input logic oad, input logic onf, input logic [31:0] ofc);
        int eh, ev, ehs, evs, ead, enf, efc;
        model(c, k, eh, ev, ehs, evs, ead, enf, efc);
        check({u, ".hcount"}, oh, eh);
        check({u, ".vcount"}, ov, ev);
        check({u, ".hs"}, {31'd0, ohs}, ehs);
        check({u, ".vs"}, {31'd0, ovs}, evs);
        check({u, ".ad"}, {31'd0, oad}, ead);
        check({u, ".nf"}, {31'd0, onf}, enf);
        check({u, ".fc"}, ofc, efc);
    endtask

    task automatic check_all();
        check_unit("u0", cfg[0], {29'd0, hc0}, {29'd0, vc0}, hs0, vs0, ad0, nf0, {30'd0, fc0});
        check_unit("u1", cfg[1], {22'd0, hc1}, {28'd0, vc1}, hs1, vs1, ad1, nf1, {30'd0, fc1});
        check_unit("u2", cfg[2], {28'd0, hc2}, {29'd0, vc2}, hs2, vs2, ad2, nf2, {31'd0, fc2});
        check_unit("u3", cfg[3], {21'd0, hc3}, {22'd0, vc3}, hs3, vs3, ad3, nf3, {26'd0, fc3});
    endtask

    // One clock: drive reset for the coming edge, advance the edge count, check mid-cycle.
    task automatic tick(input logic r);
        rst_in = r;
        @(posedge clk);
        k = r ? 0 : k + 1;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int run_len;
        int rst_left;
        bit hit;

        cfg[0] = '{ha: 4, hfp: 1, hsw: 1, hbp: 1, va: 3, vfp: 1, vsw: 1, vbp: 1,
                   fps: 3, dly: 0, hpol: 1'b1, vpol: 1'b1};
        cfg[1] = '{ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 6, vfp: 2, vsw: 2, vbp: 3,
                   fps: 3, dly: 3, hpol: 1'b0, vpol: 1'b0};
        cfg[2] = '{ha: 3, hfp: 2, hsw: 2, hbp: 2, va: 2, vfp: 1, vsw: 2, vbp: 1,
                   fps: 1, dly: 15, hpol: 1'b0, vpol: 1'b1};
        cfg[3] = '{ha: 1280, hfp: 110, hsw: 40, hbp: 220, va: 720, vfp: 5, vsw: 5, vbp: 20,
                   fps: 60, dly: 3, hpol: 1'b1, vpol: 1'b1};
        n_tests  = 0;
        n_fail   = 0;
        nf_seen0 = 0;
        k        = 0;

        // Step 1: power-up reset held for three edges; idle values checked each cycle.
        rst_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all();
        tick(1'b1);
        tick(1'b1);

        // Step 2: long clean run covering many small frames, three u1 frames, early 720p lines.
        run_len = 30000 + int'($urandom_range(2000));
        for (int i = 0; i < run_len; i++) begin
            tick(1'b0);
            if (nf0) nf_seen0++;
        end
        // u0 frame is 42 cycles and its first new-frame position is 3*7+4=25 edges in.
        check("u0.nf_total", nf_seen0, (k >= 25) ? ((k - 25) / 42 + 1) : 0);

        // Step 3: reset mid-line on the 720p unit at hcount=700, held for two edges.
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (hc3 == 11'd700) hit = 1'b1;
            else tick(1'b0);
        end
        check("u3.reach_h700", {31'd0, hit}, 32'd1);
        tick(1'b1);
        tick(1'b1);
        for (int i = 0; i < 300; i++) tick(1'b0);

        // Step 4: random short resets sprinkled through free-running operation.
        rst_left = 0;
        for (int i = 0; i < 8000; i++) begin
            if (rst_left == 0 && $urandom_range(499) == 0) rst_left = int'($urandom_range(3, 1));
            if (rst_left > 0) begin
                rst_left--;
                tick(1'b1);
            end else begin
                tick(1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
